// File: rtl/alu_multicycle.sv
// Registered ALU with a persistent 5-bit flag register; single-cycle ops plus
// an iterative WIDTH-cycle unsigned shift-add multiply.
module alu_multicycle #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic             illegal,
    output logic             dbg_state
);

    // Handshake: start is accepted on a rising edge only while busy=0; a start
    // seen while busy=1 is dropped. done pulses for exactly one cycle per
    // completion, and result/flags/illegal are valid in that cycle and held after.

    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_NOT  = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_MOV  = 8'h0D;
    localparam logic [7:0] OP_MUL  = 8'h0E;
    localparam logic [7:0] OP_LSH  = 8'h84;
    localparam logic [7:0] OP_ASHU = 8'h86;

    localparam int FC = 0;
    localparam int FL = 1;
    localparam int FF = 2;
    localparam int FZ = 3;
    localparam int FN = 4;

    localparam logic [SHW-1:0]   LAST  = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MUL_RUN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [4:0]           flags_q, flags_d;
    logic                 illegal_q, illegal_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     alu_res;
    logic [4:0]           alu_flags;
    logic                 alu_illegal;
    logic [WIDTH:0]       add_w;
    logic [WIDTH:0]       sub_w;
    logic                 sh_right;
    logic [WIDTH-1:0]     sh_mag;
    logic                 sh_big;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic                 mul_hi_nz;

    // Single-cycle datapath, evaluated on the live inputs at the accepting edge.
    always_comb begin
        alu_res     = '0;
        alu_flags   = flags_q;
        alu_illegal = 1'b0;
        add_w       = {1'b0, a} + {1'b0, b};
        sub_w       = {1'b0, a} - {1'b0, b};
        sh_right    = b[WIDTH-1];
        sh_mag      = sh_right ? (~b + 1'b1) : b;
        sh_big      = (sh_mag >= W_VAL);
        case (op)
            OP_ADD: begin
                alu_res       = add_w[WIDTH-1:0];
                alu_flags[FC] = add_w[WIDTH];
                alu_flags[FF] = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res       = sub_w[WIDTH-1:0];
                alu_flags[FC] = sub_w[WIDTH];
                alu_flags[FF] = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_CMP: begin
                alu_res       = b;
                alu_flags[FL] = (b < a);
                alu_flags[FZ] = (a == b);
                alu_flags[FN] = ($signed(b) < $signed(a));
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_MOV: alu_res = a;
            OP_LSH: begin
                if (sh_big)        alu_res = '0;
                else if (sh_right) alu_res = a >> sh_mag;
                else               alu_res = a << sh_mag;
            end
            OP_ASHU: begin
                if (sh_right) begin
                    if (sh_big) alu_res = {WIDTH{a[WIDTH-1]}};
                    else        alu_res = $unsigned($signed(a) >>> sh_mag);
                end else begin
                    if (sh_big) alu_res = '0;
                    else        alu_res = a << sh_mag;
                end
            end
            default: alu_illegal = 1'b1;
        endcase
    end

    // One multiplier bit per step: add the multiplicand into the high half when
    // the current LSB is set, then shift the whole product right by one.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
        mul_hi_nz = |mul_next[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        result_d  = result_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_d = S_MUL_RUN;
                        cnt_d   = '0;
                        prod_d  = {{WIDTH{1'b0}}, b};
                        mcand_d = a;
                    end else begin
                        result_d  = alu_res;
                        flags_d   = alu_flags;
                        illegal_d = alu_illegal;
                        done_d    = 1'b1;
                    end
                end
            end
            S_MUL_RUN: begin
                prod_d = mul_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    result_d    = mul_next[WIDTH-1:0];
                    flags_d[FC] = mul_hi_nz;
                    flags_d[FF] = mul_hi_nz;
                    illegal_d   = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            mcand_q   <= mcand_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q == S_MUL_RUN);
    assign done      = done_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign illegal   = illegal_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed vector table, multi-cycle MUL and reset
// corner sequences, then random ops against a behavioural arithmetic model.
module tb_alu_multicycle;

  localparam int W = 16;

  typedef struct {
    logic [7:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [4:0]   flg;
    logic         ill;
  } vec_t;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [7:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [4:0]   flags;
  logic         illegal;
  logic         dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [4:0]   model_flags;
  vec_t         tbl[$];
  logic [7:0]   legal_ops[11];

  alu_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .flags     (flags),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint in_range_ovf(input longint t);
    longint half;
    half = longint'(1) << (W - 1);
    return (t < -half || t >= half) ? 1 : 0;
  endfunction

  function automatic void ref_op(input logic [7:0] o, input longint ua, input longint ub,
                                 input logic [4:0] fin, output longint r,
                                 output logic [4:0] fo, output bit ill);
    longint md, half, sa, sb, s, m, p;
    md   = longint'(1) << W;
    half = longint'(1) << (W - 1);
    sa   = (ua >= half) ? ua - md : ua;
    sb   = (ub >= half) ? ub - md : ub;
    fo   = fin;
    ill  = 1'b0;
    r    = 0;
    case (o)
      8'h05: begin
        s = ua + ub; r = s % md;
        fo[0] = (s >= md); fo[2] = in_range_ovf(sa + sb) != 0;
      end
      8'h09: begin
        r = (ua - ub + md) % md;
        fo[0] = (ua < ub); fo[2] = in_range_ovf(sa - sb) != 0;
      end
      8'h0B: begin
        r = ub;
        fo[1] = (ub < ua); fo[3] = (ua == ub); fo[4] = (sb < sa);
      end
      8'h01: r = ua & ub;
      8'h02: r = ua | ub;
      8'h03: r = ua ^ ub;
      8'h07: r = (md - 1) - ua;
      8'h0D: r = ua;
      8'h84, 8'h86: begin
        if (sb >= 0) begin
          r = (sb >= W) ? 0 : ((ua << sb) % md);
        end else begin
          m = -sb;
          if (o == 8'h84)  r = (m >= W) ? 0 : (ua >> m);
          else if (m >= W) r = (sa < 0) ? md - 1 : 0;
          else             r = ((sa >>> m) + md) % md;
        end
      end
      8'h0E: begin
        p = ua * ub; r = p % md;
        fo[0] = (p >= md); fo[2] = (p >= md);
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", name, act, expv, $time);
    end
  endtask

  task automatic add_vec(input logic [7:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [W-1:0] r, input logic [4:0] f, input logic il);
    vec_t v;
    v.op = o; v.a = xa; v.b = xb; v.res = r; v.flg = f; v.ill = il;
    tbl.push_back(v);
  endtask

  // ---------------- drivers ----------------
  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    @(posedge clk); #1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_res"}, 32'(result), 32'(v.res));
    check({tag, "_flags"}, 32'(flags), 32'(v.flg));
    check({tag, "_illegal"}, 32'(illegal), 32'(v.ill));
    model_flags = v.flg;
  endtask

  task automatic issue(input logic [7:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input string tag);
    longint r; logic [4:0] f; bit il;
    ref_op(o, longint'(xa), longint'(xb), model_flags, r, f, il);
    exp_q.push_back(W'(r));
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge clk); #1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_res"}, 32'(result), 32'(exp_q.pop_front()));
    check({tag, "_flags"}, 32'(flags), 32'(f));
    check({tag, "_illegal"}, 32'(illegal), 32'(il));
    model_flags = f;
  endtask

  // chain=1 returns in the done cycle so the next issue lands there.
  task automatic do_mul(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit inject,
                        input bit chain, input string tag);
    longint r; logic [4:0] f; bit il;
    int cycles; bit got; bit busy_ok;
    ref_op(8'h0E, longint'(xa), longint'(xb), model_flags, r, f, il);
    exp_q.push_back(W'(r));
    @(negedge clk);
    start = 1'b1; op = 8'h0E; a = xa; b = xb;
    @(posedge clk); #1;
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    check({tag, "_done_early"}, 32'(done), 32'd0);
    cycles = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && cycles < 40) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      start = inject && (cycles == 2);
      op = start ? 8'h05 : 8'($urandom);
      @(posedge clk); #1;
      cycles++;
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, "_completed"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cycles), 32'(W));
    check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_res"}, 32'(result), 32'(exp_q.pop_front()));
    check({tag, "_flags"}, 32'(flags), 32'(f));
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
    model_flags = f;
    if (!chain) begin
      @(posedge clk); #1;
      check({tag, "_no_extra_done"}, 32'(done), 32'd0);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    bit saw_done;
    logic [7:0] o;
    int pick;
    logic [W-1:0] ra, rb;

    legal_ops = '{8'h05, 8'h09, 8'h01, 8'h02, 8'h03, 8'h07, 8'h0B, 8'h0D, 8'h84, 8'h86, 8'h0E};

    // Back-to-back sequence; flags persist from row to row.
    add_vec(8'h05, 16'h7FFF, 16'h0001, 16'h8000, 5'h04, 1'b0);
    add_vec(8'h09, 16'h0000, 16'h0001, 16'hFFFF, 5'h01, 1'b0);
    add_vec(8'h01, 16'hFFFF, 16'h0000, 16'h0000, 5'h01, 1'b0);
    add_vec(8'h0B, 16'h0001, 16'hFFFF, 16'hFFFF, 5'h11, 1'b0);
    add_vec(8'h0B, 16'h1234, 16'h1234, 16'h1234, 5'h09, 1'b0);
    add_vec(8'h84, 16'h8001, 16'hFFFF, 16'h4000, 5'h09, 1'b0);
    add_vec(8'h86, 16'h8001, 16'hFFFF, 16'hC000, 5'h09, 1'b0);
    add_vec(8'h84, 16'h8001, 16'h0010, 16'h0000, 5'h09, 1'b0);
    add_vec(8'h86, 16'h8000, 16'hFFEC, 16'hFFFF, 5'h09, 1'b0);
    add_vec(8'h02, 16'h00F0, 16'h0F00, 16'h0FF0, 5'h09, 1'b0);
    add_vec(8'h03, 16'hFFFF, 16'h0F0F, 16'hF0F0, 5'h09, 1'b0);
    add_vec(8'h07, 16'h1234, 16'h0000, 16'hEDCB, 5'h09, 1'b0);
    add_vec(8'h0D, 16'hABCD, 16'h5555, 16'hABCD, 5'h09, 1'b0);
    add_vec(8'hFF, 16'h1111, 16'h2222, 16'h0000, 5'h09, 1'b1);
    add_vec(8'h05, 16'hFFFF, 16'h0001, 16'h0000, 5'h09, 1'b0);
    add_vec(8'h09, 16'h8000, 16'h0001, 16'h7FFF, 5'h0C, 1'b0);
    add_vec(8'h84, 16'h0001, 16'h000F, 16'h8000, 5'h0C, 1'b0);
    add_vec(8'h86, 16'h4000, 16'h0001, 16'h8000, 5'h0C, 1'b0);
    add_vec(8'h86, 16'h0001, 16'hFFF0, 16'h0000, 5'h0C, 1'b0);
    add_vec(8'h84, 16'h8000, 16'h8000, 16'h0000, 5'h0C, 1'b0);
    add_vec(8'h0B, 16'h8000, 16'h0001, 16'h0001, 5'h06, 1'b0);

    reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    model_flags = '0;
    #3;
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) apply_vec(tbl[i], i);
    @(negedge clk);
    start = 1'b0;

    // Overflowing multiply with a dropped ADD mid-run, then a small one.
    do_mul(16'h0100, 16'h0100, 1'b1, 1'b0, "mul_ovf");
    do_mul(16'h0003, 16'h0005, 1'b0, 1'b1, "mul_small");
    issue(8'h05, 16'h0002, 16'h0003, "add_in_done_cycle");

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = 8'h0E; a = 16'h00FF; b = 16'h0101;
    @(posedge clk); #1;
    start = 1'b0;
    check("rstmul_state", 32'(dbg_state), 32'd1);
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rstmul_busy", 32'(busy), 32'd0);
    check("rstmul_done", 32'(done), 32'd0);
    check("rstmul_result", 32'(result), 32'd0);
    check("rstmul_flags", 32'(flags), 32'd0);
    check("rstmul_illegal", 32'(illegal), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_flags = '0;
    saw_done = 1'b0;
    repeat (24) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("rstmul_quiet_after", 32'(saw_done), 32'd0);

    issue(8'h05, 16'h7FFF, 16'h0001, "pre_illegal_add");
    issue(8'hFF, 16'h1234, 16'h5678, "illegal_ff");
    issue(8'h0D, 16'h4321, 16'h0000, "illegal_clear");
    @(negedge clk);
    start = 1'b0;

    // Random back-to-back traffic.
    for (int n = 0; n < 250; n++) begin
      pick = $urandom_range(0, 11);
      o = (pick == 11) ? 8'($urandom_range(0, 255)) : legal_ops[pick];
      ra = W'($urandom);
      rb = W'($urandom);
      if ((o == 8'h84 || o == 8'h86) && $urandom_range(0, 3) != 0)
        rb = W'($urandom_range(0, 40)) - W'(20);
      if ($urandom_range(0, 7) == 0) rb = ra;
      if (o == 8'h0E) do_mul(ra, rb, 1'b0, 1'b1, $sformatf("rnd%0d_mul", n));
      else            issue(o, ra, rb, $sformatf("rnd%0d_op%0h", n, o));
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("final_idle_done", 32'(done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
